videomem_wr_arb: RTL
====================

# videomem_wr_arb

Two-master write arbiter sitting directly downstream of the video-memory initialiser (master 0) and the USB frame-update writer (master 1), feeding the single burst-write port of the SDRAM controller. It grants one master per burst, forwards the request/ack/give_next_data handshake, and steers address and data. Master 0 has strict priority until initialisation completes; after that, the two masters alternate round-robin.

## Interface
- ADDR_W, 25, write address width (word address, burst-aligned)
- DATA_W, 32, write data width
- BURST_LEN, 4, data words per granted burst (power of two, ≥2)
- mem_clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- init_complete  in  1  master 0 finished; enables round-robin
- m0_wr_request / m1_wr_request  in  1  burst request, held until own req_ack
- m0_wr_addr / m1_wr_addr  in  ADDR_W  burst start address, stable while requesting
- m0_wr_data / m1_wr_data  in  DATA_W  current data word
- m0_req_ack / m1_req_ack  out  1  request-accepted pulse to that master
- m0_give_next_data / m1_give_next_data  out  1  word-consumed pulse to that master
- wr_request  out  1  burst request to controller
- wr_addr  out  ADDR_W  registered start address of granted burst
- wr_data  out  DATA_W  data of granted master
- mem_req_ack  in  1  controller accepted request (1-cycle pulse)
- give_next_data  in  1  controller consumed wr_data (1-cycle pulse)
- grant  out  1  index of current/last granted master
- busy  out  1  state ≠ IDLE
- proto_err  out  1  sticky: give_next_data outside DATA/REQ-ack, or mem_req_ack outside REQ

## Operation
- States: IDLE, REQ, DATA.
- IDLE: select a requester. If init_complete=0, only m0 is eligible. If init_complete=1 and both request, pick the one ≠ grant. Otherwise pick the sole requester. On selection, register grant and wr_addr, set wr_request=1, go to REQ.
- REQ: hold wr_request. On mem_req_ack: drive granted mX_req_ack=1 combinationally the same cycle; clear wr_request; clear beat counter; go to DATA.
- DATA: wr_data = granted master's data (combinational mux). Forward give_next_data combinationally to the granted master only; increment the counter. On the BURST_LEN-th pulse, go to IDLE.
- If give_next_data coincides with mem_req_ack, it counts as beat 0.
- The non-granted master never sees req_ack or give_next_data.
- In IDLE/REQ, wr_data follows the grant mux. Its value is don't-care to the controller.
- A protocol violation sets proto_err. The FSM ignores the offending pulse. proto_err clears only on reset.
- A stale request (the master still high in the ack cycle) is never re-granted, because the FSM is not in IDLE that cycle.

## Timing
- Reset values: wr_request=0, wr_addr=0, grant=0, busy=0, proto_err=0, all req_ack/give_next_data=0, state=IDLE, counter=0.
- Request→wr_request latency: 1 cycle (request sampled in IDLE at t, wr_request high at t+1).
- Ack and give_next_data pass-through: 0 cycles.
- Minimum gap between bursts: 1 IDLE cycle after the last beat.
- Counter width is log2(BURST_LEN). It wraps to 0 on the final beat.
- reset_n low mid-burst: immediate return to IDLE with reset values. No partial-burst recovery.
- init_complete is sampled only in IDLE. A change during a burst takes effect at the next arbitration.

## Structure
- Shared package videomem_pkg: ADDR_W, DATA_W, BURST_LEN defaults, and the state enum {IDLE, REQ, DATA}.
- One sub-module: rr_arb2 (combinational 2-way pick with priority-override input and last-grant input). The FSM, counter, and muxes live in the top module.

## Test plan
- Reset, then m0 requests addr 0x000040 with init_complete=0 → wr_request=1 and wr_addr=0x000040 one cycle later. Ack → m0_req_ack same cycle. Four give_next_data pulses → m0 sees 4 pulses, state returns to IDLE.
- init_complete=0, both request → m0 served for every burst. m1 is starved and never acked.
- init_complete=1, both request continuously → grants alternate 0,1,0,1. Each burst shows the correct master's data on wr_data.
- give_next_data in the same cycle as mem_req_ack → counted as beat 0. Burst ends after 3 further pulses.
- give_next_data pulse while IDLE → proto_err=1 and stays 1. The following normal burst completes correctly.
- reset_n asserted after beat 2 of a m1 burst → all outputs at reset values immediately. A new m0 request after release is served normally.

Source files
------------

// File: rtl/videomem_pkg.sv
// ----------------------------------------------------------------------------
// videomem_pkg
//   Shared definitions for the video-memory write path.
//   - VM_ADDR_W / VM_DATA_W / VM_BURST_LEN : default widths and burst length
//   - wr_state_t                           : arbiter FSM state encoding
// ----------------------------------------------------------------------------
package videomem_pkg;

  localparam int unsigned VM_ADDR_W    = 25;  // word address, burst-aligned
  localparam int unsigned VM_DATA_W    = 32;  // SDRAM write data width
  localparam int unsigned VM_BURST_LEN = 4;   // data words per burst (2^n, >= 2)

  // IDLE : arbitrating, nothing outstanding
  // REQ  : wr_request raised, waiting for the controller's accept pulse
  // DATA : streaming BURST_LEN words of the granted master
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } wr_state_t;

endpackage : videomem_pkg

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way arbiter pick.
//   Ports:
//     i_req[1:0]  in   request vector (bit n = master n)
//     i_prio0     in   1: only requester 0 is eligible (strict-priority mode)
//     i_last      in   index of the most recently granted requester
//     o_valid     out  an eligible requester exists
//     o_pick      out  index of the selected requester (valid with o_valid)
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_prio0,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_pick
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // if/else leaves it unassigned, which would otherwise infer a latch.
    o_valid = 1'b0;
    o_pick  = 1'b0;
    if (i_prio0) begin
      // Requester 1 is invisible until priority mode is released.
      o_valid = i_req[0];
      o_pick  = 1'b0;
    end else begin
      o_valid = |i_req;
      if (&i_req) begin
        // Both asking: hand the grant to whoever did not have it last.
        o_pick = ~i_last;
      end else begin
        // Sole requester (or none, where o_pick is unused).
        o_pick = i_req[1];
      end
    end
  end

endmodule : rr_arb2

// File: rtl/videomem_wr_arb.sv
// ----------------------------------------------------------------------------
// videomem_wr_arb
//   Two-master burst write arbiter in front of the SDRAM controller's single
//   burst-write port. Master 0 (memory initialiser) has strict priority until
//   init_complete; afterwards masters 0 and 1 (USB frame writer) alternate.
//   One master is granted per burst; request/ack/give_next_data handshakes are
//   forwarded and address/data are steered to the controller.
//
//   Ports:
//     mem_clock, reset_n           clock (rising edge), async active-low reset
//     init_complete                enables round-robin (sampled in IDLE only)
//     mX_wr_request / mX_wr_addr   burst request and start address, master X
//     mX_wr_data                   current data word of master X
//     mX_req_ack                   request-accepted pulse to master X
//     mX_give_next_data            word-consumed pulse to master X
//     wr_request / wr_addr         burst request and registered address out
//     wr_data                      granted master's data word
//     mem_req_ack                  controller accepted the request
//     give_next_data               controller consumed wr_data
//     grant                        current / last granted master
//     busy                         FSM not in IDLE
//     proto_err                    sticky handshake-violation flag
// ----------------------------------------------------------------------------
module videomem_wr_arb
  import videomem_pkg::*;
#(
  parameter int unsigned ADDR_W    = VM_ADDR_W,
  parameter int unsigned DATA_W    = VM_DATA_W,
  parameter int unsigned BURST_LEN = VM_BURST_LEN
) (
  input  logic              mem_clock,
  input  logic              reset_n,
  input  logic              init_complete,

  input  logic              m0_wr_request,
  input  logic [ADDR_W-1:0] m0_wr_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_req_ack,
  output logic              m0_give_next_data,

  input  logic              m1_wr_request,
  input  logic [ADDR_W-1:0] m1_wr_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_req_ack,
  output logic              m1_give_next_data,

  output logic              wr_request,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              mem_req_ack,
  input  logic              give_next_data,

  output logic              grant,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned      CNT_W     = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_BEAT  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wr_state_t         r_state;
  logic [CNT_W-1:0]  r_beat;
  logic              r_grant;
  logic              r_wr_request;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_proto_err;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic w_sel_valid;
  logic w_sel_pick;

  rr_arb2 u_rr_arb2 (
    .i_req   ({m1_wr_request, m0_wr_request}),
    .i_prio0 (~init_complete),
    .i_last  (r_grant),
    .o_valid (w_sel_valid),
    .o_pick  (w_sel_pick)
  );

  // --------------------------------------------------------------------------
  // Handshake qualification
  // --------------------------------------------------------------------------
  logic w_ack;        // accept pulse that the FSM honours
  logic w_beat;       // consume pulse that the FSM honours
  logic w_proto_viol; // pulse arriving where the protocol forbids it

  assign w_ack  = (r_state == REQ) && mem_req_ack;
  // A consume pulse landing on the accept cycle is already beat 0.
  assign w_beat = give_next_data && ((r_state == DATA) || w_ack);

  assign w_proto_viol = (give_next_data && !w_beat) ||
                        (mem_req_ack && (r_state != REQ));

  // --------------------------------------------------------------------------
  // FSM, beat counter, registered request/address
  // --------------------------------------------------------------------------
  always_ff @(posedge mem_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_grant      <= 1'b0;
      r_wr_request <= 1'b0;
      r_wr_addr    <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from the values present before this edge.
      if (w_proto_viol) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_sel_valid) begin
            r_grant      <= w_sel_pick;
            r_wr_addr    <= w_sel_pick ? m1_wr_addr : m0_wr_addr;
            r_wr_request <= 1'b1;
            r_state      <= REQ;
          end
        end

        REQ: begin
          if (mem_req_ack) begin
            r_wr_request <= 1'b0;
            r_beat       <= w_beat ? ONE_BEAT : '0;
            r_state      <= DATA;
          end
        end

        DATA: begin
          if (give_next_data) begin
            // Counter is exactly log2(BURST_LEN) wide: the last beat wraps it to 0.
            r_beat <= r_beat + ONE_BEAT;
            if (r_beat == LAST_BEAT) begin
              r_state <= IDLE;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Pass-through pulses reach only the granted master, in the same cycle.
  assign m0_req_ack        = w_ack  && !r_grant;
  assign m1_req_ack        = w_ack  &&  r_grant;
  assign m0_give_next_data = w_beat && !r_grant;
  assign m1_give_next_data = w_beat &&  r_grant;

  // Data follows the grant in every state; outside DATA it is don't-care.
  assign wr_data    = r_grant ? m1_wr_data : m0_wr_data;

  assign wr_request = r_wr_request;
  assign wr_addr    = r_wr_addr;
  assign grant      = r_grant;
  assign busy       = (r_state != IDLE);
  assign proto_err  = r_proto_err;

endmodule : videomem_wr_arb
